// File: rtl/axis_stream_checker.sv
// AXI-Stream beat driver plus scoreboarded receiver with an expected-beat FIFO.
// Define AXIS_CHK_BACKPRESSURE_EN to throttle s_axis_tready from an LFSR.
module axis_stream_checker #(
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 1,
  parameter  int DEST_W    = 1,
  parameter  int USER_W    = 1,
  parameter  int EXP_DEPTH = 8,
  localparam int STRB_W    = DATA_W / 8,
  localparam int AW        = $clog2(EXP_DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_tdata,
  input  logic [STRB_W-1:0] wr_tstrb,
  input  logic [STRB_W-1:0] wr_tkeep,
  input  logic              wr_tlast,
  input  logic [ID_W-1:0]   wr_tid,
  input  logic [DEST_W-1:0] wr_tdest,
  input  logic [USER_W-1:0] wr_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [STRB_W-1:0] m_axis_tstrb,
  output logic [STRB_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [ID_W-1:0]   m_axis_tid,
  output logic [DEST_W-1:0] m_axis_tdest,
  output logic [USER_W-1:0] m_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [STRB_W-1:0] s_axis_tstrb,
  input  logic [STRB_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic [ID_W-1:0]   s_axis_tid,
  input  logic [DEST_W-1:0] s_axis_tdest,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_tdata,
  input  logic [STRB_W-1:0] exp_tstrb,
  input  logic [STRB_W-1:0] exp_tkeep,
  input  logic              exp_tlast,
  input  logic [ID_W-1:0]   exp_tid,
  input  logic [DEST_W-1:0] exp_tdest,
  input  logic [USER_W-1:0] exp_tuser,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_tdata,
  output logic [STRB_W-1:0] rd_tstrb,
  output logic [STRB_W-1:0] rd_tkeep,
  output logic              rd_tlast,
  output logic [ID_W-1:0]   rd_tid,
  output logic [DEST_W-1:0] rd_tdest,
  output logic [USER_W-1:0] rd_tuser,
  output logic              match,
  output logic              mismatch,
  output logic              unexpected,
  output logic [15:0]       match_cnt,
  output logic [15:0]       err_cnt,
  output logic [AW:0]       exp_level
);

  localparam int BW = DATA_W + 2 * STRB_W + 1 + ID_W + DEST_W + USER_W;
  localparam logic [AW:0] FULL = (AW + 1)'(EXP_DEPTH);

  // transmit register
  assign wr_ready = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else if (wr_valid && wr_ready) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= wr_tdata;
      m_axis_tstrb  <= wr_tstrb;
      m_axis_tkeep  <= wr_tkeep;
      m_axis_tlast  <= wr_tlast;
      m_axis_tid    <= wr_tid;
      m_axis_tdest  <= wr_tdest;
      m_axis_tuser  <= wr_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [7:0] lfsr;
  logic       run;

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr <= 8'hA5;
      run  <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      run  <= 1'b1;
    end
  end

  assign s_axis_tready = run && lfsr[0];
`else
  logic run;

  always_ff @(posedge aclk) begin
    if (areset) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign s_axis_tready = run;
`endif

  // expected-beat FIFO
  logic [BW-1:0] mem [EXP_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;
  logic          accept;
  logic          empty;

  assign exp_level = wr_ptr - rd_ptr;
  assign exp_ready = exp_level != FULL;
  assign empty     = exp_level == '0;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign push      = exp_valid && exp_ready;
  assign pop       = accept && !empty;

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {exp_tdata, exp_tstrb, exp_tkeep,
                              exp_tlast, exp_tid, exp_tdest, exp_tuser};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [DATA_W-1:0] f_data;
  logic [STRB_W-1:0] f_strb;
  logic [STRB_W-1:0] f_keep;
  logic              f_last;
  logic [ID_W-1:0]   f_id;
  logic [DEST_W-1:0] f_dest;
  logic [USER_W-1:0] f_user;
  logic              beat_eq;

  assign {f_data, f_strb, f_keep, f_last, f_id, f_dest, f_user} =
    mem[rd_ptr[AW-1:0]];

  // data bytes only matter where the expected beat keeps them
  always_comb begin
    beat_eq = (f_strb == s_axis_tstrb) && (f_keep == s_axis_tkeep) &&
              (f_last == s_axis_tlast) && (f_id == s_axis_tid) &&
              (f_dest == s_axis_tdest) && (f_user == s_axis_tuser);
    for (int b = 0; b < STRB_W; b++) begin
      if (f_keep[b] && (f_data[8*b +: 8] != s_axis_tdata[8*b +: 8]))
        beat_eq = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_valid   <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      unexpected <= 1'b0;
      rd_tdata   <= '0;
      rd_tstrb   <= '0;
      rd_tkeep   <= '0;
      rd_tlast   <= 1'b0;
      rd_tid     <= '0;
      rd_tdest   <= '0;
      rd_tuser   <= '0;
      match_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      rd_valid   <= accept;
      match      <= pop && beat_eq;
      mismatch   <= pop && !beat_eq;
      unexpected <= accept && empty;
      if (accept) begin
        rd_tdata <= s_axis_tdata;
        rd_tstrb <= s_axis_tstrb;
        rd_tkeep <= s_axis_tkeep;
        rd_tlast <= s_axis_tlast;
        rd_tid   <= s_axis_tid;
        rd_tdest <= s_axis_tdest;
        rd_tuser <= s_axis_tuser;
      end
      if (pop && beat_eq && match_cnt != 16'hFFFF)
        match_cnt <= match_cnt + 16'd1;
      if (accept && (empty || !beat_eq) && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Loopback bench for axis_stream_checker, default build.
module tb_axis_stream_checker;

  logic        aclk = 1'b0;
  logic        areset;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_tdata;
  logic [3:0]  wr_tstrb, wr_tkeep;
  logic        wr_tlast;
  logic [0:0]  wr_tid, wr_tdest, wr_tuser;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb, m_axis_tkeep;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tid, m_axis_tdest, m_axis_tuser;
  logic        s_axis_tvalid, s_axis_tready;
  logic        exp_valid, exp_ready;
  logic [31:0] exp_tdata;
  logic [3:0]  exp_tstrb, exp_tkeep;
  logic        exp_tlast;
  logic [0:0]  exp_tid, exp_tdest, exp_tuser;
  logic        rd_valid;
  logic [31:0] rd_tdata;
  logic [3:0]  rd_tstrb, rd_tkeep;
  logic        rd_tlast;
  logic [0:0]  rd_tid, rd_tdest, rd_tuser;
  logic        match, mismatch, unexpected;
  logic [15:0] match_cnt, err_cnt;
  logic [3:0]  exp_level;
  logic        hold;

  int checks = 0;
  int errors = 0;
  int n_match = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  assign m_axis_tready = hold ? 1'b0 : s_axis_tready;
  assign s_axis_tvalid = m_axis_tvalid && !hold;

  axis_stream_checker dut (
    .aclk(aclk), .areset(areset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_tdata(wr_tdata), .wr_tstrb(wr_tstrb), .wr_tkeep(wr_tkeep),
    .wr_tlast(wr_tlast), .wr_tid(wr_tid), .wr_tdest(wr_tdest),
    .wr_tuser(wr_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(m_axis_tdata), .s_axis_tstrb(m_axis_tstrb),
    .s_axis_tkeep(m_axis_tkeep), .s_axis_tlast(m_axis_tlast),
    .s_axis_tid(m_axis_tid), .s_axis_tdest(m_axis_tdest),
    .s_axis_tuser(m_axis_tuser),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_tdata(exp_tdata), .exp_tstrb(exp_tstrb), .exp_tkeep(exp_tkeep),
    .exp_tlast(exp_tlast), .exp_tid(exp_tid), .exp_tdest(exp_tdest),
    .exp_tuser(exp_tuser),
    .rd_valid(rd_valid), .rd_tdata(rd_tdata), .rd_tstrb(rd_tstrb),
    .rd_tkeep(rd_tkeep), .rd_tlast(rd_tlast), .rd_tid(rd_tid),
    .rd_tdest(rd_tdest), .rd_tuser(rd_tuser),
    .match(match), .mismatch(mismatch), .unexpected(unexpected),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .exp_level(exp_level)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] k, input logic l);
    exp_valid = 1'b1;
    exp_tdata = d; exp_tstrb = s; exp_tkeep = k; exp_tlast = l;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic set_wr(input logic [31:0] d, input logic [3:0] s,
                        input logic [3:0] k, input logic l);
    wr_valid = 1'b1;
    wr_tdata = d; wr_tstrb = s; wr_tkeep = k; wr_tlast = l;
  endtask

  task automatic check_result(input string name, input logic m,
                              input logic mm, input logic u);
    checks++;
    if ({rd_valid, match, mismatch, unexpected} !== {1'b1, m, mm, u}) begin
      errors++;
      $display("FAIL %s: rd/m/mm/u got %b%b%b%b want 1%b%b%b", name,
               rd_valid, match, mismatch, unexpected, m, mm, u);
    end
    checks++;
    if (match_cnt !== 16'(n_match) || err_cnt !== 16'(n_err)) begin
      errors++;
      $display("FAIL %s_cnt: match_cnt %0d err_cnt %0d want %0d %0d",
               name, match_cnt, err_cnt, n_match, n_err);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    checks++;
    if ({m_axis_tvalid, s_axis_tready, rd_valid, match, mismatch,
         unexpected} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b%b%b%b want 000000",
               m_axis_tvalid, s_axis_tready, rd_valid, match, mismatch,
               unexpected);
    end
    checks++;
    if (match_cnt !== 16'd0 || err_cnt !== 16'd0 || exp_level !== 4'd0 ||
        rd_tdata !== 32'd0 || m_axis_tdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: mc %0d ec %0d lvl %0d rd %h m %h want 0",
               match_cnt, err_cnt, exp_level, rd_tdata, m_axis_tdata);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || exp_ready !== 1'b1 ||
        wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: tready %b exp_ready %b wr_ready %b want 111",
               s_axis_tready, exp_ready, wr_ready);
    end
  endtask

  task automatic test_match();
    push_exp(32'h1234ABCD, 4'hF, 4'hF, 1'b0);
    checks++;
    if (exp_level !== 4'd1) begin
      errors++;
      $display("FAIL push_level: got %0d want 1", exp_level);
    end
    set_wr(32'h1234ABCD, 4'hF, 4'hF, 1'b0);
    tick();
    wr_valid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1234ABCD) begin
      errors++;
      $display("FAIL tx_latency: tvalid %b tdata %h want 1 1234abcd",
               m_axis_tvalid, m_axis_tdata);
    end
    tick();
    n_match++;
    check_result("match", 1'b1, 1'b0, 1'b0);
    checks++;
    if (rd_tdata !== 32'h1234ABCD || exp_level !== 4'd0 ||
        m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL match_data: rd %h lvl %0d tvalid %b want 1234abcd 0 0",
               rd_tdata, exp_level, m_axis_tvalid);
    end
    tick();
    checks++;
    if ({rd_valid, match} !== 2'b00 || rd_tdata !== 32'h1234ABCD) begin
      errors++;
      $display("FAIL pulse_end: rd_valid %b match %b rd %h want 0 0 1234abcd",
               rd_valid, match, rd_tdata);
    end
  endtask

  task automatic test_mismatch();
    push_exp(32'h1234ABCD, 4'hF, 4'hF, 1'b0);
    set_wr(32'h1234ABCE, 4'hF, 4'hF, 1'b0);
    tick();
    wr_valid = 1'b0;
    tick();
    n_err++;
    check_result("mismatch", 1'b0, 1'b1, 1'b0);
    checks++;
    if (exp_level !== 4'd0) begin
      errors++;
      $display("FAIL mismatch_pop: level %0d want 0", exp_level);
    end
    tick();
  endtask

  task automatic test_keep_mask();
    push_exp(32'h0000ABCD, 4'h3, 4'h3, 1'b0);
    set_wr(32'hFFFFABCD, 4'h3, 4'h3, 1'b0);
    tick();
    wr_valid = 1'b0;
    tick();
    n_match++;
    check_result("keep_mask", 1'b1, 1'b0, 1'b0);
    checks++;
    if (rd_tkeep !== 4'h3 || rd_tdata !== 32'hFFFFABCD) begin
      errors++;
      $display("FAIL keep_rd: keep %h data %h want 3 ffffabcd",
               rd_tkeep, rd_tdata);
    end
    tick();
    push_exp(32'h0000ABCD, 4'h3, 4'h3, 1'b0);
    set_wr(32'h0000ABCC, 4'h3, 4'h3, 1'b0);
    tick();
    wr_valid = 1'b0;
    tick();
    n_err++;
    check_result("keep_low_byte", 1'b0, 1'b1, 1'b0);
    tick();
    push_exp(32'h55AA55AA, 4'hF, 4'hF, 1'b1);
    set_wr(32'h55AA55AA, 4'hF, 4'hF, 1'b0);
    tick();
    wr_valid = 1'b0;
    tick();
    n_err++;
    check_result("tlast_diff", 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_unexpected();
    set_wr(32'h0BADF00D, 4'hF, 4'hF, 1'b1);
    tick();
    wr_valid = 1'b0;
    tick();
    n_err++;
    check_result("unexpected", 1'b0, 1'b0, 1'b1);
    checks++;
    if (exp_level !== 4'd0 || rd_tlast !== 1'b1) begin
      errors++;
      $display("FAIL unexp_level: level %0d tlast %b want 0 1",
               exp_level, rd_tlast);
    end
    tick();
  endtask

  task automatic test_backpressure();
    push_exp(32'hDEADBEEF, 4'hF, 4'hF, 1'b0);
    hold = 1'b1;
    set_wr(32'hDEADBEEF, 4'hF, 4'hF, 1'b0);
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hDEADBEEF ||
          wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: tvalid %b data %h wr_ready %b rd %b want 1 deadbeef 0 0",
                 i, m_axis_tvalid, m_axis_tdata, wr_ready, rd_valid);
      end
      tick();
    end
    hold = 1'b0;
    tick();
    n_match++;
    check_result("release", 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b0 || rd_tdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL release_data: tvalid %b rd %h want 0 deadbeef",
               m_axis_tvalid, rd_tdata);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_beat: rd_valid %b want 0", rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    d[0] = 32'hA0A0A0A0;
    d[1] = 32'hB1B1B1B1;
    d[2] = 32'hC2C2C2C2;
    for (int i = 0; i < 3; i++) push_exp(d[i], 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_wr(d[i], 4'hF, 4'hF, 1'b0);
      else wr_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 3) begin
        n_match++;
        check_result("b2b", 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_tdata !== d[i-1]) begin
          errors++;
          $display("FAIL b2b_data_%0d: got %h want %h", i - 1, rd_tdata,
                   d[i-1]);
        end
      end
    end
    checks++;
    if (exp_level !== 4'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: level %0d rd_valid %b want 0 0",
               exp_level, rd_valid);
    end
  endtask

  task automatic test_fifo_full();
    hold = 1'b1;
    set_wr(32'h77777777, 4'hF, 4'hF, 1'b0);
    tick();
    wr_valid = 1'b0;
    exp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_tdata = 32'(i);
      tick();
    end
    checks++;
    if (exp_level !== 4'd8 || exp_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: level %0d exp_ready %b want 8 0",
               exp_level, exp_ready);
    end
    exp_tdata = 32'hFFFFFFFF;
    tick();
    exp_valid = 1'b0;
    checks++;
    if (exp_level !== 4'd8) begin
      errors++;
      $display("FAIL ninth_push: level %0d want 8", exp_level);
    end
    areset = 1'b1;
    tick();
    checks++;
    if (exp_level !== 4'd0 || match_cnt !== 16'd0 || err_cnt !== 16'd0 ||
        m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: lvl %0d mc %0d ec %0d tvalid %b tready %b want 0",
               exp_level, match_cnt, err_cnt, m_axis_tvalid, s_axis_tready);
    end
    areset = 1'b0;
    hold = 1'b0;
    n_match = 0;
    n_err = 0;
    tick();
    checks++;
    if (exp_ready !== 1'b1 || s_axis_tready !== 1'b1 ||
        m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: exp_ready %b tready %b tvalid %b want 1 1 0",
               exp_ready, s_axis_tready, m_axis_tvalid);
    end
  endtask

  initial begin
    areset = 1'b1;
    hold = 1'b0;
    wr_valid = 1'b0;
    wr_tdata = '0; wr_tstrb = '0; wr_tkeep = '0; wr_tlast = 1'b0;
    wr_tid = '0; wr_tdest = '0; wr_tuser = '0;
    exp_valid = 1'b0;
    exp_tdata = '0; exp_tstrb = '0; exp_tkeep = '0; exp_tlast = 1'b0;
    exp_tid = '0; exp_tdest = '0; exp_tuser = '0;
    test_reset();
    test_match();
    test_mismatch();
    test_keep_mask();
    test_unexpected();
    test_backpressure();
    test_back_to_back();
    test_fifo_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- Synthesizable AXI-Stream stimulus/check block: a transmit side that drives single beats onto a master stream from a write-command port, and a receive side that accepts beats from a slave stream and scores each one against a queue of expected beats.
- Used in loopback and self-checking benches: master output wired to the stream under test, slave input taking the returned stream; scoreboard status exported as pulses and counters.

Parameters:
- DATA_W, 32, tdata width; multiple of 8. STRB_W = DATA_W/8 (derived) sizes tstrb/tkeep.
- ID_W, 1, tid width.
- DEST_W, 1, tdest width.
- USER_W, 1, tuser width.
- EXP_DEPTH, 8, expected-beat FIFO depth; power of 2, >= 2.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- wr_valid / wr_ready  in / out  1  write-command handshake.
- wr_tdata, wr_tstrb, wr_tkeep, wr_tlast, wr_tid, wr_tdest, wr_tuser  in  DATA_W/STRB_W/STRB_W/1/ID_W/DEST_W/USER_W  beat to transmit.
- m_axis_tvalid, m_axis_tdata … m_axis_tuser  out  same widths  master stream; m_axis_tready in 1.
- s_axis_tvalid, s_axis_tdata … s_axis_tuser  in  same widths  slave stream; s_axis_tready out 1.
- exp_valid / exp_ready  in / out  1  expected-beat push handshake.
- exp_tdata … exp_tuser  in  same field set  expected beat.
- rd_valid  out  1  one-cycle pulse: a beat was accepted on s_axis.
- rd_tdata … rd_tuser  out  same field set  last accepted beat, held until next accept.
- match, mismatch, unexpected  out  1 each  one-cycle result pulses, coincident with rd_valid.
- match_cnt, err_cnt  out  16 each  saturating counters.
- exp_level  out  clog2(EXP_DEPTH)+1  expected-FIFO occupancy.

Behaviour:
- Reset: m_axis_tvalid=0, s_axis_tready=0, rd_valid/match/mismatch/unexpected=0, rd_* fields=0, counters=0, FIFO emptied (exp_level=0). m_axis data fields reset to 0.
- Transmit: single output register. wr_ready = !m_axis_tvalid || m_axis_tready (combinational). On wr_valid&&wr_ready, load all fields and set m_axis_tvalid next cycle (latency 1). While tvalid&&!tready, m_axis fields and tvalid held stable. On tready without a new write, tvalid clears. Back-to-back writes sustain 1 beat/cycle.
- Receive: beat accepted when s_axis_tvalid&&s_axis_tready. Next cycle: rd_valid=1, rd_* = captured beat, exactly one of match/mismatch/unexpected = 1.
- Comparison (front of FIFO, sampled at accept): tdata compared only on bytes where the expected tkeep bit is 1; tstrb, tkeep, tlast, tid, tdest, tuser compared exactly. All equal -> match; else mismatch. FIFO popped on every accept when non-empty.
- FIFO empty at accept -> unexpected, no pop.
- Expected FIFO: exp_ready = (exp_level != EXP_DEPTH). Push on exp_valid&&exp_ready. Same-cycle push and pop: level unchanged, order preserved. A push in the same cycle as an accept on an empty FIFO is not visible to that beat (beat flagged unexpected; pushed entry remains).
- match_cnt increments on match; err_cnt on mismatch or unexpected; both saturate at 16'hFFFF.
- Reset mid-transfer: pending m_axis beat dropped; FIFO contents and counters discarded.

Optional Feature:
- Macro AXIS_CHK_BACKPRESSURE_EN.
- Defined: s_axis_tready = bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5 on reset, advancing every cycle; tready 0 during reset.
- Undefined: s_axis_tready = 1 every cycle out of reset, 0 during reset.

Test Plan:
- Loopback m_axis->s_axis. After reset, push exp {tdata 32'h1234ABCD, tstrb 4'hF, tkeep 4'hF, tlast 0, tid 0, tdest 0, tuser 0}; write identical beat -> m_axis_tvalid 1 cycle after accept; rd_valid with rd_tdata 32'h1234ABCD; match pulse; match_cnt=1, err_cnt=0, exp_level=0.
- Expect 32'h1234ABCD, send 32'h1234ABCE -> mismatch pulse, err_cnt=1, FIFO popped.
- Expect tkeep 4'h3 tdata 32'h0000ABCD, send 32'hFFFFABCD tkeep 4'h3 -> match (masked upper bytes).
- Send beat with FIFO empty -> unexpected pulse, err_cnt=1, exp_level stays 0.
- Hold m_axis_tready=0 for 5 cycles after write 32'hDEADBEEF -> tvalid and data stable, wr_ready=0; release -> single beat transferred.
- Push 8 expected beats -> exp_ready=0, exp_level=8; 9th push ignored; assert areset 1 cycle -> exp_level=0, counters 0, tvalid/tready 0.
